// File: rtl/seg_scan_decoder_if.sv
// Display-bus interface for the scan decoder: the observed segment and
// digit-select lines plus the decoded frame results.
// Handshake: there is no valid/ready pair here. seg/digit are free-running
// and asynchronous to clk. frame_valid is a one-cycle pulse that marks
// value/dp/err_mask/frame_err as freshly updated; those outputs hold until
// the next pulse. timeout is an independent one-cycle pulse.
interface seg_scan_decoder_if;
    logic [7:0]  seg;
    logic [3:0]  digit;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        frame_valid;
    logic        frame_err;
    logic [3:0]  err_mask;
    logic        timeout;

    // Display driver / observer side
    modport master (
        output seg, digit,
        input  value, dp, frame_valid, frame_err, err_mask, timeout
    );

    // Decoder side
    modport slave (
        input  seg, digit,
        output value, dp, frame_valid, frame_err, err_mask, timeout
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Seven-segment scan decoder: synchronizes a multiplexed 4-digit display
// bus, waits for each scan slot to settle, decodes the segment pattern back
// to a hex nibble and publishes a 16-bit value once all four digits have
// been captured. Undecodable patterns and stalled scans are flagged.
module seg_scan_decoder #(
    parameter int STABLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 1048576,
    parameter int CNT_W       = 20
) (
    input  logic              clk,
    input  logic              rstb,
    seg_scan_decoder_if.slave bus,
    output logic [1:0]        fsm_state
);
    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [7:0]       seg_meta, seg_sync;
    logic [3:0]       dig_meta, dig_sync;
    logic [11:0]      samp, samp_prev;
    logic             change, slot_valid;
    logic [1:0]       slot_idx;
    logic [3:0]       slot_bit;
    logic [3:0]       nib_dec;
    logic             dec_err;
    state_t           state, state_nx;
    logic [CNT_W-1:0] stab_cnt, stab_cnt_nx;
    logic             capture;
    logic [15:0]      nib_r;
    logic [3:0]       dp_r, err_r;
    logic [3:0]       mask, mask_base, mask_nx;
    logic             pend, pend_nx;
    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_fire;
    logic [15:0]      value_r;
    logic [3:0]       dp_out, err_mask_r;
    logic             frame_err_r, frame_valid_r;

    // Two-flop synchronizers plus the one-cycle-old sample for change detect
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            seg_meta  <= '0;
            seg_sync  <= '0;
            dig_meta  <= '0;
            dig_sync  <= '0;
            samp_prev <= '0;
        end else begin
            seg_meta  <= bus.seg;
            seg_sync  <= seg_meta;
            dig_meta  <= bus.digit;
            dig_sync  <= dig_meta;
            samp_prev <= samp;
        end
    end

    assign samp   = {dig_sync, seg_sync};
    assign change = (samp != samp_prev);

    // A slot is valid only when exactly one active-low select is asserted
    always_comb begin
        slot_valid = 1'b1;
        slot_idx   = 2'd0;
        case (dig_sync)
            4'b1110: slot_idx = 2'd0;
            4'b1101: slot_idx = 2'd1;
            4'b1011: slot_idx = 2'd2;
            4'b0111: slot_idx = 2'd3;
            default: slot_valid = 1'b0;
        endcase
        slot_bit = 4'b0001 << slot_idx;
    end

    // Segment pattern (g..a) back to a hex nibble; unknown codes decode to 0
    always_comb begin
        nib_dec = 4'h0;
        dec_err = 1'b0;
        case (seg_sync[6:0])
            7'h3F: nib_dec = 4'h0;
            7'h06: nib_dec = 4'h1;
            7'h5B: nib_dec = 4'h2;
            7'h4F: nib_dec = 4'h3;
            7'h66: nib_dec = 4'h4;
            7'h6D: nib_dec = 4'h5;
            7'h7D: nib_dec = 4'h6;
            7'h07: nib_dec = 4'h7;
            7'h7F: nib_dec = 4'h8;
            7'h6F: nib_dec = 4'h9;
            7'h77: nib_dec = 4'hA;
            7'h7C: nib_dec = 4'hB;
            7'h39: nib_dec = 4'hC;
            7'h5E: nib_dec = 4'hD;
            7'h79: nib_dec = 4'hE;
            7'h71: nib_dec = 4'hF;
            default: dec_err = 1'b1;
        endcase
    end

    // Slot settling FSM: next state, stability count and capture strobe
    always_comb begin
        state_nx    = state;
        stab_cnt_nx = stab_cnt;
        capture     = 1'b0;
        case (state)
            ST_WAIT: begin
                stab_cnt_nx = '0;
                if (slot_valid) begin
                    state_nx    = ST_SETTLE;
                    stab_cnt_nx = CNT_ONE;
                end
            end
            ST_SETTLE: begin
                if (change) begin
                    if (slot_valid) begin
                        stab_cnt_nx = CNT_ONE;
                    end else begin
                        state_nx    = ST_WAIT;
                        stab_cnt_nx = '0;
                    end
                end else begin
                    stab_cnt_nx = stab_cnt + CNT_ONE;
                    if (stab_cnt_nx == STABLE_LAST) begin
                        capture  = 1'b1;
                        state_nx = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (change) begin
                    if (slot_valid) begin
                        state_nx    = ST_SETTLE;
                        stab_cnt_nx = CNT_ONE;
                    end else begin
                        state_nx    = ST_WAIT;
                        stab_cnt_nx = '0;
                    end
                end
            end
            default: begin
                state_nx    = ST_WAIT;
                stab_cnt_nx = '0;
            end
        endcase
    end

    // FSM state and stability counter registers
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state    <= ST_WAIT;
            stab_cnt <= '0;
        end else begin
            state    <= state_nx;
            stab_cnt <= stab_cnt_nx;
        end
    end

    // Per-position capture of nibble, dp and decode error
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            nib_r <= '0;
            dp_r  <= '0;
            err_r <= '0;
        end else if (capture) begin
            nib_r[{slot_idx, 2'b00} +: 4] <= nib_dec;
            dp_r[slot_idx]                <= seg_sync[7];
            err_r[slot_idx]               <= dec_err;
        end
    end

    // Mask bookkeeping: a frame completes only on the transition into 4'hF;
    // a pending completion outranks a coincident timeout
    always_comb begin
        tmo_fire  = (tmo_cnt == TMO_LAST) && !pend;
        mask_base = tmo_fire ? 4'b0000 : mask;
        mask_nx   = mask_base;
        pend_nx   = 1'b0;
        if (pend) begin
            mask_nx = 4'b0000;
        end else if (capture) begin
            mask_nx = mask_base | slot_bit;
            pend_nx = (mask_nx == 4'hF) && (mask_base != 4'hF);
        end
    end

    // Mask, timeout counter and published frame registers
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            mask          <= '0;
            pend          <= 1'b0;
            tmo_cnt       <= '0;
            frame_valid_r <= 1'b0;
            value_r       <= '0;
            dp_out        <= '0;
            err_mask_r    <= '0;
            frame_err_r   <= 1'b0;
        end else begin
            mask          <= mask_nx;
            pend          <= pend_nx;
            frame_valid_r <= pend;
            tmo_cnt       <= (pend || tmo_fire) ? '0 : tmo_cnt + CNT_ONE;
            if (pend) begin
                value_r     <= nib_r;
                dp_out      <= dp_r;
                err_mask_r  <= err_r;
                frame_err_r <= |err_r;
            end
        end
    end

    assign bus.value       = value_r;
    assign bus.dp          = dp_out;
    assign bus.err_mask    = err_mask_r;
    assign bus.frame_err   = frame_err_r;
    assign bus.frame_valid = frame_valid_r;
    assign bus.timeout     = tmo_fire;
    assign fsm_state       = state;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scenarios from the test plan plus
// randomized scans scored against a run-length reference model.
module tb_seg_scan_decoder;
    localparam int STABLE = 4;
    localparam int TMO    = 64;
    localparam int TAIL   = 12;

    logic       clk  = 1'b0;
    logic       rstb = 1'b0;
    logic [1:0] fsm_state;

    seg_scan_decoder_if bus();

    seg_scan_decoder #(
        .STABLE_CYC (STABLE),
        .TIMEOUT_CYC(TMO),
        .CNT_W      (8)
    ) dut (
        .clk      (clk),
        .rstb     (rstb),
        .bus      (bus.slave),
        .fsm_state(fsm_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_chg = 0;
    int rel_cyc  = 0;
    int fv_cyc   = 0;
    int to_cnt   = 0;
    int to_cyc   = 0;

    // {frame_err, err_mask[3:0], dp[3:0], value[15:0]}
    logic [24:0] exp_q[$];
    logic [24:0] obs_q[$];
    logic [3:0]  slot_d[$];
    logic [7:0]  slot_s[$];
    int          slot_n[$];

    logic [6:0] codes [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record published frames and timeout pulses
    always @(negedge clk) begin
        if (rstb && bus.frame_valid) begin
            obs_q.push_back({bus.frame_err, bus.err_mask, bus.dp, bus.value});
            fv_cyc = cyc;
        end
        if (rstb && bus.timeout) begin
            if (to_cnt == 0) to_cyc = cyc;
            to_cnt++;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [4:0] lookup(input logic [6:0] c);
        for (int k = 0; k < 16; k++)
            if (codes[k] == c) return {1'b0, 4'(k)};
        return 5'b10000;
    endfunction

    // Collapse the stimulus into runs of constant {digit,seg}; each valid run
    // lasting STABLE cycles fills its position, and filling the last empty
    // position yields one frame.
    function automatic void model_frames();
        logic [3:0]  mask = 4'b0;
        logic [3:0]  dpb  = 4'b0;
        logic [3:0]  errb = 4'b0;
        logic [15:0] nibs = 16'h0;
        int i = 0;
        exp_q.delete();
        while (i < slot_d.size()) begin
            logic [3:0] d;
            logic [7:0] s;
            logic [4:0] dec;
            int len, j, k;
            d = slot_d[i];
            s = slot_s[i];
            len = slot_n[i];
            j = i + 1;
            while (j < slot_d.size() && slot_d[j] == d && slot_s[j] == s) begin
                len += slot_n[j];
                j++;
            end
            if (j == slot_d.size()) len += TAIL;
            if ($countones(~d) == 1 && len >= STABLE) begin
                k = 0;
                for (int b = 0; b < 4; b++) if (!d[b]) k = b;
                dec = lookup(s[6:0]);
                nibs[k*4 +: 4] = dec[3:0];
                dpb[k]  = s[7];
                errb[k] = dec[4];
                if (mask != 4'hF && (mask | (4'b0001 << k)) == 4'hF) begin
                    exp_q.push_back({|errb, errb, dpb, nibs});
                    mask = 4'b0;
                end else begin
                    mask = mask | (4'b0001 << k);
                end
            end
            i = j;
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [3:0] d, input logic [7:0] s, input int n);
        bus.digit = d;
        bus.seg   = s;
        last_chg  = cyc;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstb      = 1'b0;
        bus.digit = 4'hF;
        bus.seg   = 8'h00;
        @(negedge clk);
        rstb    = 1'b1;
        rel_cyc = cyc;
        to_cnt  = 0;
        obs_q.delete();
    endtask

    task automatic add_slot(input logic [3:0] d, input logic [7:0] s, input int n);
        slot_d.push_back(d);
        slot_s.push_back(s);
        slot_n.push_back(n);
    endtask

    task automatic run_slots();
        for (int i = 0; i < slot_d.size(); i++) drive(slot_d[i], slot_s[i], slot_n[i]);
        repeat (TAIL) @(negedge clk);
        #1;
    endtask

    function automatic logic [7:0] rand_seg();
        if ($urandom_range(0, 3) != 0)
            return {1'($urandom_range(0, 1)), codes[$urandom_range(0, 15)]};
        return 8'($urandom);
    endfunction

    function automatic logic [3:0] rand_invalid();
        logic [3:0] d;
        do d = 4'($urandom_range(0, 15)); while ($countones(~d) == 1);
        return d;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.digit = 4'hF;
        bus.seg   = 8'h00;
        rstb      = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.value !== 16'h0) $display("FAIL reset_value: got %h expected 0000", bus.value);
        else n_pass++;
        n_checks++;
        if ({bus.dp, bus.err_mask, bus.frame_err} !== 9'h0)
            $display("FAIL reset_flags: got dp=%b err_mask=%b frame_err=%b expected zeros",
                     bus.dp, bus.err_mask, bus.frame_err);
        else n_pass++;
        n_checks++;
        if ({bus.frame_valid, bus.timeout, fsm_state} !== 4'h0)
            $display("FAIL reset_pulses: got fv=%b to=%b state=%0d expected 0",
                     bus.frame_valid, bus.timeout, fsm_state);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [24:0] got;
        do_reset();
        drive(4'b1110, 8'h06, 10);
        drive(4'b1101, 8'h5B, 10);
        drive(4'b1011, 8'h4F, 10);
        drive(4'b0111, 8'h66, 10);
        repeat (TAIL) @(negedge clk);
        #1;
        got = (obs_q.size() > 0) ? obs_q[0] : 'x;
        n_checks++;
        if (obs_q.size() !== 1) $display("FAIL basic_count: got %0d frames expected 1", obs_q.size());
        else n_pass++;
        n_checks++;
        if (got[15:0] !== 16'h4321) $display("FAIL basic_value: got %h expected 4321", got[15:0]);
        else n_pass++;
        n_checks++;
        if (got[24:16] !== 9'h0) $display("FAIL basic_flags: got %h expected 000", got[24:16]);
        else n_pass++;
        n_checks++;
        if (fv_cyc - last_chg !== 2 + STABLE + 1)
            $display("FAIL basic_latency: got %0d expected %0d", fv_cyc - last_chg, 2 + STABLE + 1);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [24:0] g0, g1;
        obs_q.delete();
        drive(4'b1110, 8'h3F, 10);
        drive(4'b1101, 8'h3F, 10);
        drive(4'b1011, 8'hFC, 10);
        drive(4'b0111, 8'h3F, 10);
        drive(4'b1110, 8'h3F, 10);
        drive(4'b1101, 8'h7E, 10);
        drive(4'b1011, 8'h3F, 10);
        drive(4'b0111, 8'h3F, 10);
        repeat (TAIL) @(negedge clk);
        #1;
        g0 = (obs_q.size() > 0) ? obs_q[0] : 'x;
        g1 = (obs_q.size() > 1) ? obs_q[1] : 'x;
        n_checks++;
        if (obs_q.size() !== 2) $display("FAIL b2b_count: got %0d frames expected 2", obs_q.size());
        else n_pass++;
        n_checks++;
        if (g0[15:0] !== 16'h0B00) $display("FAIL dp_value: got %h expected 0b00", g0[15:0]);
        else n_pass++;
        n_checks++;
        if (g0[19:16] !== 4'b0100) $display("FAIL dp_bits: got %b expected 0100", g0[19:16]);
        else n_pass++;
        n_checks++;
        if (g1[15:0] !== 16'h0000) $display("FAIL err_value: got %h expected 0000", g1[15:0]);
        else n_pass++;
        n_checks++;
        if (g1[24:20] !== 5'b10010)
            $display("FAIL err_flags: got frame_err=%b err_mask=%b expected 1 0010", g1[24], g1[23:20]);
        else n_pass++;
    endtask

    task automatic test_timeout();
        logic [3:0] digs [4];
        digs = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        do_reset();
        for (int i = 0; i < 24; i++) drive(digs[i % 4], 8'h06, STABLE - 1);
        #1;
        n_checks++;
        if (to_cnt !== 1) $display("FAIL timeout_count: got %0d expected 1", to_cnt);
        else n_pass++;
        n_checks++;
        if (to_cyc - rel_cyc !== TMO - 1)
            $display("FAIL timeout_cycle: got %0d expected %0d", to_cyc - rel_cyc, TMO - 1);
        else n_pass++;
        n_checks++;
        if (obs_q.size() !== 0) $display("FAIL short_slot_frames: got %0d expected 0", obs_q.size());
        else n_pass++;
        n_checks++;
        if (bus.value !== 16'h0) $display("FAIL timeout_value: got %h expected 0000", bus.value);
        else n_pass++;
    endtask

    task automatic test_glitch_resettle();
        logic [24:0] got;
        do_reset();
        drive(4'b1110, 8'h3F, 10);
        drive(4'b1100, 8'h06, 2);
        drive(4'b1101, 8'h06, 3);
        drive(4'b1101, 8'h5B, 10);
        drive(4'b1011, 8'h4F, 6);
        drive(4'b1011, 8'h66, 10);
        drive(4'b0111, 8'h7F, 10);
        repeat (TAIL) @(negedge clk);
        #1;
        got = (obs_q.size() > 0) ? obs_q[0] : 'x;
        n_checks++;
        if (obs_q.size() !== 1) $display("FAIL glitch_count: got %0d frames expected 1", obs_q.size());
        else n_pass++;
        n_checks++;
        if (got !== {9'h0, 16'h8420}) $display("FAIL glitch_frame: got %h expected %h", got, {9'h0, 16'h8420});
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [24:0] got;
        do_reset();
        drive(4'b1110, 8'h6D, 10);
        drive(4'b1101, 8'h7D, 10);
        drive(4'b1011, 8'h07, 10);
        drive(4'b0111, 8'h6F, 10);
        repeat (TAIL) @(negedge clk);
        #1;
        n_checks++;
        if (bus.value !== 16'h9765) $display("FAIL pre_reset_value: got %h expected 9765", bus.value);
        else n_pass++;
        drive(4'b1110, 8'h39, 10);
        drive(4'b1101, 8'h5E, 10);
        drive(4'b1011, 8'h79, 10);
        @(negedge clk);
        rstb = 1'b0;
        #1;
        n_checks++;
        if (bus.value !== 16'h0) $display("FAIL mid_reset_value: got %h expected 0000", bus.value);
        else n_pass++;
        n_checks++;
        if ({bus.dp, bus.err_mask, bus.frame_err} !== 9'h0)
            $display("FAIL mid_reset_flags: got %h expected 000", {bus.dp, bus.err_mask, bus.frame_err});
        else n_pass++;
        @(negedge clk);
        rstb = 1'b1;
        obs_q.delete();
        drive(4'b0111, 8'h71, 10);
        drive(4'b1011, 8'h06, 10);
        drive(4'b1101, 8'h5B, 10);
        drive(4'b1110, 8'h4F, 10);
        repeat (TAIL) @(negedge clk);
        #1;
        got = (obs_q.size() > 0) ? obs_q[0] : 'x;
        n_checks++;
        if (obs_q.size() !== 1) $display("FAIL post_reset_count: got %0d frames expected 1", obs_q.size());
        else n_pass++;
        n_checks++;
        if (got[15:0] !== 16'hF123) $display("FAIL post_reset_value: got %h expected f123", got[15:0]);
        else n_pass++;
    endtask

    task automatic test_random(input int iters);
        for (int it = 0; it < iters; it++) begin
            int perm [4];
            int r, t;
            logic [3:0] d;
            for (int k = 0; k < 4; k++) perm[k] = k;
            for (int k = 3; k > 0; k--) begin
                r = $urandom_range(0, k);
                t = perm[k];
                perm[k] = perm[r];
                perm[r] = t;
            end
            slot_d.delete();
            slot_s.delete();
            slot_n.delete();
            for (int k = 0; k < 4; k++) begin
                d = ~(4'b0001 << perm[k]);
                if ($urandom_range(0, 3) == 0) add_slot(rand_invalid(), rand_seg(), $urandom_range(1, 2));
                if ($urandom_range(0, 9) < 3) add_slot(d, rand_seg(), $urandom_range(1, 5));
                add_slot(d, rand_seg(), $urandom_range(STABLE - 1, 6));
            end
            model_frames();
            do_reset();
            run_slots();
            n_checks++;
            if (obs_q.size() !== exp_q.size())
                $display("FAIL rand_count[%0d]: got %0d frames expected %0d", it, obs_q.size(), exp_q.size());
            else n_pass++;
            for (int f = 0; f < exp_q.size() && f < obs_q.size(); f++) begin
                n_checks++;
                if (obs_q[f] !== exp_q[f])
                    $display("FAIL rand_frame[%0d.%0d]: got %h expected %h", it, f, obs_q[f], exp_q[f]);
                else n_pass++;
            end
        end
    endtask

    // Test sequence and summary
    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_timeout();
        test_glitch_resettle();
        test_reset_mid();
        test_random(20);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
